// File: rtl/pet_stats_engine.sv
// rtl/pet_stats_engine.sv - pet statistics core: decaying saturating stats, action handshake, death latch
//
// Holds NUM_STATS saturating counters. A prescaler produces a decay tick every
// TICK_DIV enabled cycles. Each tick starts a scan that decrements one stat per
// cycle, then a one-cycle check that latches DEAD when enough stats are zero.
// Player actions replenish a stat through a valid/ready handshake.
//
// Optional feature macro: STATS_RAND_DECAY_EN
//   defined   : during a scan, stat[idx] decrements only when rand_in[idx % 8] is 1
//   undefined : every stat decrements once per scan, rand_in is ignored
//
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   ena          in   prescaler advance enable
//   rand_in      in   [7:0] random byte (used only with STATS_RAND_DECAY_EN)
//   action_valid in   action request
//   action_id    in   [2:0] stat index to replenish
//   action_ready out  action can be accepted this cycle (combinational)
//   action_err   out  one-cycle pulse after an accepted out-of-range action_id
//   stats_flat   out  [NUM_STATS*STAT_W-1:0] stat i at [i*STAT_W +: STAT_W]
//   critical     out  [NUM_STATS-1:0] registered stat <= CRIT_LEVEL flags
//   tick         out  one-cycle pulse after each prescaler wrap
//   alive        out  0 once the pet is dead
module pet_stats_engine #(
  parameter int NUM_STATS   = 6,
  parameter int STAT_W      = 4,
  parameter int TICK_DIV    = 10_000_000,
  parameter int ACTION_STEP = 3,
  parameter int COST_IDX    = 4,
  parameter int CRIT_LEVEL  = 2,
  parameter int DEATH_ZEROS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [7:0]                    rand_in,
  input  logic                          action_valid,
  input  logic [2:0]                    action_id,
  output logic                          action_ready,
  output logic                          action_err,
  output logic [NUM_STATS*STAT_W-1:0]   stats_flat,
  output logic [NUM_STATS-1:0]          critical,
  output logic                          tick,
  output logic                          alive
);

  localparam int IDX_W = $clog2(NUM_STATS);
  localparam int CNT_W = $clog2(TICK_DIV);

  localparam logic [STAT_W-1:0] STAT_MAX     = {STAT_W{1'b1}};
  localparam logic [STAT_W:0]   STAT_MAX_EXT = {1'b0, STAT_MAX};
  localparam logic [STAT_W:0]   STEP_EXT     = (STAT_W+1)'(ACTION_STEP);
  localparam logic [STAT_W-1:0] CRIT_VAL     = STAT_W'(CRIT_LEVEL);
  localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST     = IDX_W'(NUM_STATS - 1);
  localparam logic [3:0]        NUM_STATS_4  = 4'(NUM_STATS);
  localparam logic [2:0]        COST_ID3     = 3'(COST_IDX);
  localparam logic [3:0]        DEATH_Z4     = 4'(DEATH_ZEROS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_CHECK,
    S_DEAD
  } state_e;

  state_e               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [STAT_W-1:0]    stats_q [NUM_STATS];
  logic [STAT_W-1:0]    stats_d [NUM_STATS];
  logic [NUM_STATS-1:0] crit_q;
  logic                 tick_q;
  logic                 err_q;
  logic                 alive_q;

  logic                 wrap;
  logic                 action_fire;
  logic                 id_valid;
  logic                 dec_en;
  logic [3:0]           zero_cnt;

  function automatic logic [STAT_W-1:0] sat_dec(input logic [STAT_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] v);
    logic [STAT_W:0] sum;
    sum = {1'b0, v} + STEP_EXT;
    return (sum > STAT_MAX_EXT) ? STAT_MAX : sum[STAT_W-1:0];
  endfunction

  // The prescaler is frozen once dead, so no wrap (and no tick) can occur there.
  assign wrap         = (cnt_q == CNT_LAST) && ena && (state_q != S_DEAD);
  // A wrap cycle starts a scan, so an action on that edge would collide with it.
  assign action_ready = (state_q == S_IDLE) && !wrap;
  assign action_fire  = action_valid && action_ready;
  assign id_valid     = ({1'b0, action_id} < NUM_STATS_4);

`ifdef STATS_RAND_DECAY_EN
  logic [2:0] rand_sel;
  assign rand_sel = 3'(idx_q);
  assign dec_en   = rand_in[rand_sel];
`else
  logic unused_rand;
  assign unused_rand = ^rand_in;
  assign dec_en      = 1'b1;
`endif

  always_comb begin
    zero_cnt = '0;
    for (int i = 0; i < NUM_STATS; i++) begin
      zero_cnt = zero_cnt + {3'b000, (stats_q[i] == '0)};
    end
  end

  // Scan and actions are mutually exclusive (ready is low outside IDLE).
  always_comb begin
    stats_d = stats_q;
    if (state_q == S_SCAN) begin
      if (dec_en) begin
        stats_d[idx_q] = sat_dec(stats_q[idx_q]);
      end
    end else if (action_fire && id_valid) begin
      stats_d[action_id[IDX_W-1:0]] = sat_add(stats_q[action_id[IDX_W-1:0]]);
      if (action_id != COST_ID3) begin
        stats_d[COST_IDX] = sat_dec(stats_q[COST_IDX]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STATS; i++) begin
        stats_q[i] <= STAT_MAX;
      end
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      crit_q  <= '0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
      alive_q <= 1'b1;
    end else begin
      stats_q <= stats_d;
      tick_q  <= wrap;
      err_q   <= action_fire && !id_valid;
      for (int i = 0; i < NUM_STATS; i++) begin
        crit_q[i] <= (stats_q[i] <= CRIT_VAL);
      end

      if ((state_q != S_DEAD) && ena) begin
        cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (wrap) begin
            state_q <= S_SCAN;
            idx_q   <= '0;
          end
        end
        S_SCAN: begin
          if (idx_q == IDX_LAST) begin
            state_q <= S_CHECK;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_CHECK: begin
          if (zero_cnt >= DEATH_Z4) begin
            state_q <= S_DEAD;
            alive_q <= 1'b0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_DEAD;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_STATS; g++) begin : g_flat
    assign stats_flat[g*STAT_W +: STAT_W] = stats_q[g];
  end

  assign critical   = crit_q;
  assign tick       = tick_q;
  assign action_err = err_q;
  assign alive      = alive_q;

endmodule
